noc_node_if: RTL and testbench

//  - Parametrised network interface between a processing element and its router's local (5th) port.
//  - Buffers PE traffic into an injection FIFO and forwards it to the router under credit-based flow control.
//  - Buffers ejected router flits into an ejection FIFO and returns one credit per flit the PE consumes.
//  - Successor to the fixed 20-bit direct PE<->router hookup: width, depths and credit count are generic.

---
 rtl/noc_node_if.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_noc_node_if.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_node_if.sv
// -----------------------------------------------------------------------------
// noc_node_if
//
// Network interface between a processing element (PE) and the local (5th)
// port of its router.
//   * Injection path: PE flits are buffered in an injection FIFO. They are
//     forwarded to the router only while the credit counter shows a free slot
//     in the router's local input buffer. The inject output is registered.
//   * Ejection path: router flits are buffered in an ejection FIFO. The head of
//     that FIFO is presented to the PE first-word-fall-through. Each flit the
//     PE consumes returns one credit to the router through a registered
//     eject_cr pulse, issued in the cycle after the pop.
//
// Parameters
//   FLIT_W      flit width in bits
//   INJ_DEPTH   injection FIFO entries (power of 2, >= 2)
//   EJ_DEPTH    ejection FIFO entries (power of 2, >= 2); the router holds this
//               many credits for this port
//   RTR_CREDITS depth of the router local input buffer; the credit counter
//               starts at this value
//
// Ports
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   pe_tx_data/valid    flit offered by the PE; pe_tx_ready = injection FIFO not full
//   pe_rx_data/valid    head of the ejection FIFO; pe_rx_ready pops it
//   inject/inject_valid registered flit toward the router local input
//   inject_cr           credit pulse from the router (one local input slot freed)
//   eject/eject_valid   flit from the router local output
//   eject_cr            registered credit pulse back to the router
//   err                 sticky: [0] credit overflow, [1] ejection FIFO overflow
//
// Optional build macro NOC_NI_STATS_EN
//   When defined, three extra outputs are added: tx_cnt (flits sent on inject),
//   rx_cnt (flits popped by the PE) and stall_cnt (cycles with a flit waiting
//   and no credit). The counters wrap at 2^32. When undefined these ports do
//   not exist and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module noc_node_if #(
    parameter int FLIT_W      = 20,
    parameter int INJ_DEPTH   = 4,
    parameter int EJ_DEPTH    = 4,
    parameter int RTR_CREDITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] pe_tx_data,
    input  logic              pe_tx_valid,
    output logic              pe_tx_ready,
    output logic [FLIT_W-1:0] pe_rx_data,
    output logic              pe_rx_valid,
    input  logic              pe_rx_ready,
    output logic [FLIT_W-1:0] inject,
    output logic              inject_valid,
    input  logic              inject_cr,
    input  logic [FLIT_W-1:0] eject,
    input  logic              eject_valid,
    output logic              eject_cr,
    output logic [1:0]        err
`ifdef NOC_NI_STATS_EN
    ,
    output logic [31:0]       tx_cnt,
    output logic [31:0]       rx_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int INJ_AW = $clog2(INJ_DEPTH);
    localparam int EJ_AW  = $clog2(EJ_DEPTH);
    localparam int INJ_CW = $clog2(INJ_DEPTH + 1);
    localparam int EJ_CW  = $clog2(EJ_DEPTH + 1);
    localparam int CR_W   = $clog2(RTR_CREDITS + 1);

    localparam logic [INJ_CW-1:0] INJ_FULL_C  = INJ_CW'(INJ_DEPTH);
    localparam logic [EJ_CW-1:0]  EJ_FULL_C   = EJ_CW'(EJ_DEPTH);
    localparam logic [CR_W-1:0]   CR_MAX_C    = CR_W'(RTR_CREDITS);
    localparam logic [INJ_CW-1:0] INJ_ZERO_C  = {INJ_CW{1'b0}};
    localparam logic [EJ_CW-1:0]  EJ_ZERO_C   = {EJ_CW{1'b0}};
    localparam logic [CR_W-1:0]   CR_ZERO_C   = {CR_W{1'b0}};
    localparam logic [INJ_CW-1:0] INJ_ONE_C   = INJ_CW'(1);
    localparam logic [EJ_CW-1:0]  EJ_ONE_C    = EJ_CW'(1);
    localparam logic [CR_W-1:0]   CR_ONE_C    = CR_W'(1);
    localparam logic [INJ_AW-1:0] INJ_PINC_C  = INJ_AW'(1);
    localparam logic [EJ_AW-1:0]  EJ_PINC_C   = EJ_AW'(1);

    // ------------------------------------------------------------------
    // Injection path state
    // ------------------------------------------------------------------
    logic [FLIT_W-1:0] inj_mem_r [INJ_DEPTH];
    logic [INJ_AW-1:0] inj_wr_ptr_r;
    logic [INJ_AW-1:0] inj_rd_ptr_r;
    logic [INJ_CW-1:0] inj_count_r;
    logic [INJ_CW-1:0] inj_count_nxt_s;
    logic [CR_W-1:0]   credit_r;
    logic [CR_W-1:0]   credit_nxt_s;
    logic              cr_ovf_s;
    logic [FLIT_W-1:0] inject_r;
    logic              inject_valid_r;
    logic              inj_push_s;
    logic              inj_send_s;
    logic              inj_nonempty_s;
    logic              tx_ready_s;

    // ------------------------------------------------------------------
    // Ejection path state
    // ------------------------------------------------------------------
    logic [FLIT_W-1:0] ej_mem_r [EJ_DEPTH];
    logic [EJ_AW-1:0]  ej_wr_ptr_r;
    logic [EJ_AW-1:0]  ej_rd_ptr_r;
    logic [EJ_CW-1:0]  ej_count_r;
    logic [EJ_CW-1:0]  ej_count_nxt_s;
    logic              ej_full_s;
    logic              ej_pop_s;
    logic              ej_wr_s;
    logic              ej_drop_s;
    logic              rx_valid_s;
    logic              eject_cr_r;
    logic [1:0]        err_r;

    assign inj_nonempty_s = (inj_count_r != INJ_ZERO_C);
    assign tx_ready_s     = (inj_count_r != INJ_FULL_C);
    assign inj_push_s     = pe_tx_valid & tx_ready_s;
    // A flit leaves only when the router has room for it.
    assign inj_send_s     = inj_nonempty_s & (credit_r != CR_ZERO_C);

    assign ej_full_s  = (ej_count_r == EJ_FULL_C);
    assign rx_valid_s = (ej_count_r != EJ_ZERO_C);
    assign ej_pop_s   = rx_valid_s & pe_rx_ready;
    // When full, a same-cycle pop frees the slot the write pointer targets.
    assign ej_wr_s    = eject_valid & (~ej_full_s | ej_pop_s);
    assign ej_drop_s  = eject_valid & ej_full_s & ~ej_pop_s;

    assign pe_tx_ready  = tx_ready_s;
    assign pe_rx_valid  = rx_valid_s;
    assign pe_rx_data   = ej_mem_r[ej_rd_ptr_r];
    assign inject       = inject_r;
    assign inject_valid = inject_valid_r;
    assign eject_cr     = eject_cr_r;
    assign err          = err_r;

    // Injection FIFO occupancy after this cycle's push/send.
    always_comb begin
        inj_count_nxt_s = inj_count_r;
        case ({inj_push_s, inj_send_s})
            2'b10:   inj_count_nxt_s = inj_count_r + INJ_ONE_C;
            2'b01:   inj_count_nxt_s = inj_count_r - INJ_ONE_C;
            default: inj_count_nxt_s = inj_count_r;
        endcase
    end

    // Credit counter update; a credit returned while already at the maximum saturates and flags overflow.
    always_comb begin
        credit_nxt_s = credit_r;
        cr_ovf_s     = 1'b0;
        case ({inj_send_s, inject_cr})
            2'b10: begin
                credit_nxt_s = credit_r - CR_ONE_C;
                cr_ovf_s     = 1'b0;
            end
            2'b01: begin
                if (credit_r == CR_MAX_C) begin
                    credit_nxt_s = credit_r;
                    cr_ovf_s     = 1'b1;
                end else begin
                    credit_nxt_s = credit_r + CR_ONE_C;
                    cr_ovf_s     = 1'b0;
                end
            end
            default: begin
                credit_nxt_s = credit_r;
                cr_ovf_s     = 1'b0;
            end
        endcase
    end

    // Ejection FIFO occupancy after this cycle's write/pop.
    always_comb begin
        ej_count_nxt_s = ej_count_r;
        case ({ej_wr_s, ej_pop_s})
            2'b10:   ej_count_nxt_s = ej_count_r + EJ_ONE_C;
            2'b01:   ej_count_nxt_s = ej_count_r - EJ_ONE_C;
            default: ej_count_nxt_s = ej_count_r;
        endcase
    end

    // Injection FIFO storage (contents are don't-care until pointed at).
    always_ff @(posedge clk) begin
        if (inj_push_s) begin
            inj_mem_r[inj_wr_ptr_r] <= pe_tx_data;
        end
    end

    // Ejection FIFO storage (contents are don't-care until pointed at).
    always_ff @(posedge clk) begin
        if (ej_wr_s) begin
            ej_mem_r[ej_wr_ptr_r] <= eject;
        end
    end

    // Injection pointers, count, credits and the registered inject output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_wr_ptr_r   <= {INJ_AW{1'b0}};
            inj_rd_ptr_r   <= {INJ_AW{1'b0}};
            inj_count_r    <= INJ_ZERO_C;
            credit_r       <= CR_MAX_C;
            inject_r       <= {FLIT_W{1'b0}};
            inject_valid_r <= 1'b0;
        end else begin
            inj_count_r <= inj_count_nxt_s;
            credit_r    <= credit_nxt_s;
            if (inj_push_s) begin
                inj_wr_ptr_r <= inj_wr_ptr_r + INJ_PINC_C;
            end
            if (inj_send_s) begin
                inject_r       <= inj_mem_r[inj_rd_ptr_r];
                inject_valid_r <= 1'b1;
                inj_rd_ptr_r   <= inj_rd_ptr_r + INJ_PINC_C;
            end else begin
                inject_valid_r <= 1'b0;
            end
        end
    end

    // Ejection pointers, count and the credit-return pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ej_wr_ptr_r <= {EJ_AW{1'b0}};
            ej_rd_ptr_r <= {EJ_AW{1'b0}};
            ej_count_r  <= EJ_ZERO_C;
            eject_cr_r  <= 1'b0;
        end else begin
            ej_count_r <= ej_count_nxt_s;
            eject_cr_r <= ej_pop_s;
            if (ej_wr_s) begin
                ej_wr_ptr_r <= ej_wr_ptr_r + EJ_PINC_C;
            end
            if (ej_pop_s) begin
                ej_rd_ptr_r <= ej_rd_ptr_r + EJ_PINC_C;
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 2'b00;
        end else begin
            err_r <= err_r | {ej_drop_s, cr_ovf_s};
        end
    end

`ifdef NOC_NI_STATS_EN
    logic [31:0] tx_cnt_r;
    logic [31:0] rx_cnt_r;
    logic [31:0] stall_cnt_r;

    assign tx_cnt    = tx_cnt_r;
    assign rx_cnt    = rx_cnt_r;
    assign stall_cnt = stall_cnt_r;

    // Traffic statistics; all counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_r    <= 32'd0;
            rx_cnt_r    <= 32'd0;
            stall_cnt_r <= 32'd0;
        end else begin
            if (inj_send_s) begin
                tx_cnt_r <= tx_cnt_r + 32'd1;
            end
            if (ej_pop_s) begin
                rx_cnt_r <= rx_cnt_r + 32'd1;
            end
            if (inj_nonempty_s && (credit_r == CR_ZERO_C)) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_node_if.sv
// -----------------------------------------------------------------------------
// tb_noc_node_if
//
// Scoreboard bench for noc_node_if. Stimulus pushes expected inject flits and
// expected PE-side flits into queues; a monitor on the falling clock edge pops
// and compares whenever the DUT presents inject_valid or a PE pop, and checks
// that every eject_cr pulse follows a pop by exactly one cycle.
// -----------------------------------------------------------------------------
module tb_noc_node_if;
    localparam int FLIT_W = 20;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] pe_tx_data;
    logic              pe_tx_valid;
    logic              pe_tx_ready;
    logic [FLIT_W-1:0] pe_rx_data;
    logic              pe_rx_valid;
    logic              pe_rx_ready;
    logic [FLIT_W-1:0] inject;
    logic              inject_valid;
    logic              inject_cr;
    logic [FLIT_W-1:0] eject;
    logic              eject_valid;
    logic              eject_cr;
    logic [1:0]        err;
`ifdef NOC_NI_STATS_EN
    logic [31:0]       tx_cnt;
    logic [31:0]       rx_cnt;
    logic [31:0]       stall_cnt;
`endif

    noc_node_if #(
        .FLIT_W(FLIT_W), .INJ_DEPTH(4), .EJ_DEPTH(4), .RTR_CREDITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .pe_tx_data(pe_tx_data), .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready),
        .pe_rx_data(pe_rx_data), .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready),
        .inject(inject), .inject_valid(inject_valid), .inject_cr(inject_cr),
        .eject(eject), .eject_valid(eject_valid), .eject_cr(eject_cr),
        .err(err)
`ifdef NOC_NI_STATS_EN
        , .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int inj_seen    = 0;
    int rx_seen     = 0;
    int cr_seen     = 0;
    logic prev_pop  = 1'b0;
    logic [FLIT_W-1:0] inj_exp_q[$];
    logic [FLIT_W-1:0] rx_exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pop = 1'b0;
            end else begin
                if (inject_valid) begin
                    inj_seen++;
                    if (inj_exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL inject_unexpected: got 0x%0h expected no flit", inject);
                    end else begin
                        check("inject_data", 32'(inject), 32'(inj_exp_q.pop_front()));
                    end
                end
                check("eject_cr_timing", 32'(eject_cr), 32'(prev_pop));
                if (eject_cr) cr_seen++;
                prev_pop = pe_rx_valid & pe_rx_ready;
                if (prev_pop) begin
                    rx_seen++;
                    if (rx_exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rx_unexpected: got 0x%0h expected no flit", pe_rx_data);
                    end else begin
                        check("rx_data", 32'(pe_rx_data), 32'(rx_exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic push_tx(input logic [FLIT_W-1:0] d);
        pe_tx_data  = d;
        pe_tx_valid = 1'b1;
        inj_exp_q.push_back(d);
        check("tx_ready", 32'(pe_tx_ready), 32'd1);
        tick(1);
        pe_tx_valid = 1'b0;
    endtask

    task automatic push_ej(input logic [FLIT_W-1:0] d);
        eject       = d;
        eject_valid = 1'b1;
        rx_exp_q.push_back(d);
        tick(1);
        eject_valid = 1'b0;
    endtask

    task automatic credit_pulses(input int n);
        inject_cr = 1'b1;
        tick(n);
        inject_cr = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b1; pe_tx_data = '0; pe_tx_valid = 1'b0; pe_rx_ready = 1'b0;
        inject_cr = 1'b0; eject = '0; eject_valid = 1'b0;
        tick(2);
        check("rst_inject_valid", 32'(inject_valid), 32'd0);
        check("rst_eject_cr", 32'(eject_cr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tx_ready", 32'(pe_tx_ready), 32'd1);
        check("rst_rx_valid", 32'(pe_rx_valid), 32'd0);
        rst = 1'b0;
        tick(1);

        // Single flit: visible on inject one edge after the push edge.
        pe_tx_data = 20'h12345; pe_tx_valid = 1'b1; inj_exp_q.push_back(20'h12345);
        tick(1);
        pe_tx_valid = 1'b0;
        check("lat_not_early", 32'(inject_valid), 32'd0);
        tick(1);
        check("lat_valid", 32'(inject_valid), 32'd1);
        check("lat_data", 32'(inject), 32'h12345);
        tick(1);
        check("lat_one_cycle", 32'(inject_valid), 32'd0);
        credit_pulses(1);

        // Six flits, four credits: four go, two wait.
        for (int i = 0; i < 6; i++) push_tx(20'hA0000 + 20'(i));
        tick(3);
        check("burst_sent", 32'(inj_seen), 32'd5);
        check("burst_stalled", 32'(inject_valid), 32'd0);
        check("burst_tx_ready", 32'(pe_tx_ready), 32'd1);
        credit_pulses(1);
        tick(3);
        check("one_credit_one_flit", 32'(inj_seen), 32'd6);
        credit_pulses(1);
        tick(3);
        check("last_flit", 32'(inj_seen), 32'd7);
        credit_pulses(4);
        tick(1);

        // Send and credit in the same cycle: counter stays at 4.
        push_tx(20'hB0B0B);
        inject_cr = 1'b1;
        tick(1);
        inject_cr = 1'b0;
        check("send_cr_valid", 32'(inject_valid), 32'd1);
        check("send_cr_no_err", 32'(err), 32'd0);
        tick(1);
        credit_pulses(1);
        check("cr_overflow", 32'(err), 32'd1);
        for (int i = 0; i < 5; i++) push_tx(20'hC0000 + 20'(i));
        tick(3);
        check("saturated_at_4", 32'(inj_seen), 32'd12);
        credit_pulses(1);
        tick(3);
        check("sat_drain", 32'(inj_seen), 32'd13);
        credit_pulses(4);
        tick(1);

        // Ejection: fill, overflow, drain.
        pe_rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_ej(20'hE0000 + 20'(i));
        check("ej_valid", 32'(pe_rx_valid), 32'd1);
        check("ej_head", 32'(pe_rx_data), 32'hE0000);
        eject = 20'hE0004; eject_valid = 1'b1;
        tick(1);
        eject_valid = 1'b0;
        check("ej_overflow", 32'(err), 32'd3);
        check("ej_head_kept", 32'(pe_rx_data), 32'hE0000);
        check("ej_no_cr", 32'(cr_seen), 32'd0);
        pe_rx_ready = 1'b1;
        tick(4);
        pe_rx_ready = 1'b0;
        tick(2);
        check("ej_drained", 32'(pe_rx_valid), 32'd0);
        check("ej_cr_count", 32'(cr_seen), 32'd4);
        check("ej_q_empty", 32'(rx_exp_q.size()), 32'd0);

        // Reset in the middle of traffic discards everything.
        pe_tx_data = 20'hD0D0D; pe_tx_valid = 1'b1;
        eject = 20'h6666; eject_valid = 1'b1;
        tick(1);
        rst = 1'b1; pe_tx_valid = 1'b0; eject_valid = 1'b0;
        inj_exp_q.delete(); rx_exp_q.delete();
        tick(1);
        check("mid_rst_inject_valid", 32'(inject_valid), 32'd0);
        check("mid_rst_eject_cr", 32'(eject_cr), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_tx_ready", 32'(pe_tx_ready), 32'd1);
        check("mid_rst_rx_valid", 32'(pe_rx_valid), 32'd0);
        inj_seen = 0; rx_seen = 0; cr_seen = 0;
        rst = 1'b0;
        tick(1);
        for (int i = 0; i < 5; i++) push_tx(20'h50000 + 20'(i));
        tick(3);
        check("post_rst_credits_4", 32'(inj_seen), 32'd4);
        credit_pulses(1);
        tick(3);
        check("post_rst_drain", 32'(inj_seen), 32'd5);
        credit_pulses(4);

        // Full ejection FIFO with simultaneous pop and write.
        for (int i = 0; i < 4; i++) push_ej(20'hF0000 + 20'(i));
        eject = 20'hF0004; eject_valid = 1'b1; pe_rx_ready = 1'b1;
        rx_exp_q.push_back(20'hF0004);
        tick(1);
        eject_valid = 1'b0; pe_rx_ready = 1'b0;
        check("full_pop_wr_no_err", 32'(err), 32'd0);
        check("full_pop_wr_head", 32'(pe_rx_data), 32'hF0001);
        pe_rx_ready = 1'b1;
        tick(4);
        pe_rx_ready = 1'b0;
        tick(2);
        check("full_pop_wr_drained", 32'(pe_rx_valid), 32'd0);
        check("full_pop_wr_cr", 32'(cr_seen), 32'd5);
        check("rx_q_empty", 32'(rx_exp_q.size()), 32'd0);
        check("inj_q_empty", 32'(inj_exp_q.size()), 32'd0);
`ifdef NOC_NI_STATS_EN
        check("stats_tx", tx_cnt, 32'd5);
        check("stats_rx", rx_cnt, 32'd5);
        check("stats_stall", stall_cnt, 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
